riscv_fetch_buffer: RTL and testbench
=====================================

# riscv_fetch_buffer

Parametrised instruction-fetch front end for the pipelined RISC-V core, replacing the single IF/ID register with a DEPTH-entry prefetch queue. It issues in-order instruction memory requests on a valid/ready handshake, tracks outstanding responses, and presents {pc, inst} to the ID stage with backpressure. Branch and jump redirects flush the queue and discard in-flight responses, generalising the current single-cycle squash.

## Interface
- XLEN, 32: address/PC width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  core clock.
- x_reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; in order, at least 1 cycle after acceptance.
- imem_rsp_inst  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch (branch/jump/trap).
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0.
- id_valid  out  1  head entry holds a filled instruction.
- id_inst  out  32  head instruction.
- id_pc  out  XLEN  head PC.
- id_ready  in  1  ID stage consumes the head.
- occupancy  out  $clog2(DEPTH)+1  entries allocated, both pending and filled.

## Operation
- Queue entries are reserved at request time. The PC is written at the alloc pointer when imem_req_valid & imem_req_ready. The response writes the instruction at the fill pointer and sets its filled bit. The head pointer advances on id_valid & id_ready.
- Request rule: imem_req_valid = !x_reset & !redirect_valid & (occupancy < DEPTH).
  - imem_req_addr = fetch_pc.
  - fetch_pc increments by 4 on acceptance and wraps modulo 2^XLEN.
- id_valid = filled bit of the head entry.
- Redirect cycle:
  - All entries are cleared; head, alloc and fill are set equal; occupancy becomes 0.
  - fetch_pc <= redirect_pc & ~3.
  - drop_cnt <= pending-unfilled count minus imem_rsp_valid in that cycle.
  - A response arriving in the redirect cycle is discarded.
- Responses arriving while drop_cnt != 0 decrement drop_cnt and are not written. drop_cnt saturates at 0.
- New requests may issue while drops are pending. Responses stay in order, so drops always drain first.
- An id handshake in a redirect cycle counts as consumed by ID; the rest of the queue is flushed.
- A response with no pending and no drop outstanding is ignored; simulation assertion fires.
- No FSM beyond the counters: head, alloc and fill pointers are $clog2(DEPTH)+1 bits with a wrap bit, and drop_cnt is $clog2(DEPTH)+1 bits.

## Timing
- Reset values while x_reset is high: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, occupancy=0, drop_cnt=0.
- First request is in the first clk edge cycle after x_reset deasserts, with addr RESET_PC.
- Response to id_valid latency: 1 cycle (registered fill).
- Redirect to first new request: 1 cycle (request appears the cycle after redirect_valid).
- Full: occupancy==DEPTH holds imem_req_valid low. An id handshake in that cycle frees a slot, and the request reasserts the next cycle; there is no same-cycle re-grant.
- Empty: id_valid low, and id_inst/id_pc hold their last values.
- Simultaneous fill and consume at the same entry: consume only if already filled before the edge (non-bypass build).
- Reset mid-stream: all pointers and drop_cnt clear asynchronously, and outstanding memory responses after reset are ignored. The memory side must also be reset.

## Configuration
- RISCV_FETCH_BYPASS_EN defined: when the queue head is the entry being filled by imem_rsp_valid (and drop_cnt==0), id_valid asserts in the same cycle with id_inst = imem_rsp_inst. Response to id_valid latency is then 0. If id_ready is high, the entry is consumed without being marked filled.
- Not defined: latency is strictly 1 cycle and there is no combinational path from imem_rsp_* to id_*.

## Test plan
- Reset release, imem_req_ready=1, 1-cycle memory latency, id_ready=1 -> requests at 0x0,0x4,0x8 on consecutive cycles; id_pc 0x0 with matching inst is seen 2 cycles after the first request (1 with BYPASS_EN).
- id_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 and occupancy=4; one id handshake -> next request (0x10) the following cycle.
- Memory with 3-cycle latency and 3 pending; redirect_valid with redirect_pc=0x103 -> queue empty, next request addr 0x100, the 3 stale responses dropped, first id_pc=0x100.
- Redirect in the same cycle as a response, with 2 pending -> drop_cnt=1; exactly one further response discarded.
- fetch_pc=0xFFFF_FFFC (XLEN=32) accepted -> next addr 0x0000_0000, both delivered in order.
- x_reset pulsed asynchronously mid-burst with 2 pending -> all outputs at reset values immediately; first post-reset request at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_buffer_if.sv
// Handshake bundle between riscv_fetch_buffer, instruction memory and the ID stage.
// master = fetch buffer side, slave = memory/ID side.
interface riscv_fetch_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned OccW = $clog2(DEPTH) + 1;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;
    logic [OccW-1:0] occupancy;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, occupancy,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_inst, redirect_valid, redirect_pc,
               id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, occupancy,
        output imem_req_ready, imem_rsp_valid, imem_rsp_inst, redirect_valid, redirect_pc,
               id_ready
    );
endinterface

// File: rtl/riscv_fetch_buffer.sv
// DEPTH-entry instruction prefetch queue: entries reserved at request, filled in order by responses.
// Define RISCV_FETCH_BYPASS_EN to forward a response straight to ID when it fills the head entry.
module riscv_fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                  clk,
    input logic                  x_reset,
    riscv_fetch_buffer_if.master bus
);
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    typedef logic [PtrW-1:0] ptr_t;
    localparam ptr_t PtrOne   = ptr_t'(1);
    localparam ptr_t PtrDepth = ptr_t'(DEPTH);

    ptr_t            head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
    ptr_t            drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, last_pc_q, last_pc_d;
    logic [31:0]     last_inst_q, last_inst_d;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;

    ptr_t            occ, pending;
    logic [IdxW-1:0] head_idx, alloc_idx, fill_idx;
    logic            req_fire, rsp_take, rsp_drop, id_fire;
    logic [PtrW:0]   drop_sum;

    assign occ       = alloc_q - head_q;
    assign pending   = alloc_q - fill_q;
    assign head_idx  = head_q[IdxW-1:0];
    assign alloc_idx = alloc_q[IdxW-1:0];
    assign fill_idx  = fill_q[IdxW-1:0];

    assign bus.imem_req_valid = !x_reset && !bus.redirect_valid && (occ < PtrDepth);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.occupancy      = occ;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_take = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q == '0) &&
                      (pending != '0);
    assign rsp_drop = bus.imem_rsp_valid && !bus.redirect_valid && (drop_cnt_q != '0);
    assign id_fire  = bus.id_valid && bus.id_ready;

`ifdef RISCV_FETCH_BYPASS_EN
    logic bypass;
    // Head is the pending entry this response fills.
    assign bypass = rsp_take && (fill_q == head_q);

    always_comb begin
        bus.id_valid = filled_q[head_idx] || bypass;
        bus.id_pc    = (filled_q[head_idx] || bypass) ? pc_q[head_idx] : last_pc_q;
        if (filled_q[head_idx]) begin
            bus.id_inst = inst_q[head_idx];
        end else if (bypass) begin
            bus.id_inst = bus.imem_rsp_inst;
        end else begin
            bus.id_inst = last_inst_q;
        end
    end
`else
    always_comb begin
        bus.id_valid = filled_q[head_idx];
        bus.id_pc    = filled_q[head_idx] ? pc_q[head_idx] : last_pc_q;
        bus.id_inst  = filled_q[head_idx] ? inst_q[head_idx] : last_inst_q;
    end
`endif

    always_comb begin
        head_d      = head_q;
        alloc_d     = alloc_q;
        fill_d      = fill_q;
        drop_cnt_d  = drop_cnt_q;
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        filled_d    = filled_q;
        last_pc_d   = bus.id_valid ? bus.id_pc : last_pc_q;
        last_inst_d = bus.id_valid ? bus.id_inst : last_inst_q;
        drop_sum    = {1'b0, drop_cnt_q} + {1'b0, pending};

        if (bus.redirect_valid) begin
            filled_d   = '0;
            head_d     = alloc_q;
            fill_d     = alloc_q;
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            // Every response still owed by memory must be dropped, minus one arriving now.
            if (bus.imem_rsp_valid && drop_sum != '0) begin
                drop_sum = drop_sum - (PtrW + 1)'(1);
            end
            drop_cnt_d = drop_sum[PtrW] ? '1 : drop_sum[PtrW-1:0];
        end else begin
            if (req_fire) begin
                pc_d[alloc_idx] = fetch_pc_q;
                alloc_d         = alloc_q + PtrOne;
                fetch_pc_d      = fetch_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - PtrOne;
            end
            if (rsp_take) begin
                inst_d[fill_idx]   = bus.imem_rsp_inst;
                filled_d[fill_idx] = 1'b1;
                fill_d             = fill_q + PtrOne;
            end
            // Clearing after the fill leaves a bypassed-and-consumed entry unfilled.
            if (id_fire) begin
                filled_d[head_idx] = 1'b0;
                head_d             = head_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk or posedge x_reset) begin
        if (x_reset) begin
            head_q      <= '0;
            alloc_q     <= '0;
            fill_q      <= '0;
            drop_cnt_q  <= '0;
            fetch_pc_q  <= RESET_PC;
            last_pc_q   <= '0;
            last_inst_q <= '0;
            pc_q        <= '{default: '0};
            inst_q      <= '{default: '0};
            filled_q    <= '0;
        end else begin
            head_q      <= head_d;
            alloc_q     <= alloc_d;
            fill_q      <= fill_d;
            drop_cnt_q  <= drop_cnt_d;
            fetch_pc_q  <= fetch_pc_d;
            last_pc_q   <= last_pc_d;
            last_inst_q <= last_inst_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            filled_q    <= filled_d;
        end
    end

    // A response with nothing pending and nothing to drop means the memory side lost sync.
    assert property (@(posedge clk) disable iff (x_reset)
        !(bus.imem_rsp_valid && !bus.redirect_valid && drop_cnt_q == '0 && pending == '0));
endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Directed bench for riscv_fetch_buffer: in-order memory model plus a PC/instruction scoreboard.
module tb_riscv_fetch_buffer;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RISCV_FETCH_BYPASS_EN
    localparam int FillLat = 1;
`else
    localparam int FillLat = 2;
`endif

    logic clk = 1'b0;
    logic x_reset;

    riscv_fetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    riscv_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .x_reset(x_reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
    typedef struct {int due; logic [31:0] pc;} mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          tests, fails, cyc, mem_lat, n_req, base;
    int          first_req_cyc, first_id_cyc;
    logic [31:0] exp_fetch_pc, prev_id_pc, first_pc_after;
    logic        arm_first, wrap_seen;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sampled at the active edge, before the DUT's state updates.
    task automatic mon_step();
        exp_t e;
        cyc++;
        if (x_reset) return;
        if (bus.id_valid && first_id_cyc < 0) first_id_cyc = cyc;
        if (bus.id_valid && bus.id_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("id_pc", bus.id_pc, e.pc);
                chk("id_inst", bus.id_inst, e.inst);
            end
            if (arm_first) begin
                first_pc_after = bus.id_pc;
                arm_first      = 1'b0;
            end
            if (bus.id_pc == 32'h0 && prev_id_pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            prev_id_pc = bus.id_pc;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_fetch_pc);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            n_req++;
            exp_q.push_back('{pc: exp_fetch_pc, inst: inst_of(exp_fetch_pc)});
            mem_q.push_back('{due: cyc + mem_lat - 1, pc: bus.imem_req_addr});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (bus.redirect_valid) begin
            exp_q.delete();
            exp_fetch_pc = bus.redirect_pc & ~32'h3;
        end
    endtask

    task automatic mem_step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_inst  = 32'h0;
        if (x_reset) begin
            mem_q.delete();
            return;
        end
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_inst  = inst_of(mem_q[0].pc);
            void'(mem_q.pop_front());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
        chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({tag, "_id_inst"}, bus.id_inst, 32'd0);
        chk({tag, "_id_pc"}, bus.id_pc, 32'd0);
        chk({tag, "_occ"}, 32'(bus.occupancy), 32'd0);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; mem_lat = 1; n_req = 0; base = 0;
        first_req_cyc = -1; first_id_cyc = -1;
        exp_fetch_pc = RESET_PC; prev_id_pc = 32'h0; first_pc_after = 32'hFFFF_FFFF;
        arm_first = 1'b0; wrap_seen = 1'b0;
        x_reset = 1'b1;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_inst = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;

        fork
            forever begin @(posedge clk); mon_step(); end
            forever begin @(negedge clk); mem_step(); end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("rst");

        // Streaming with 1-cycle memory
        @(negedge clk);
        x_reset = 1'b0; bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
        #1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, RESET_PC);
        repeat (6) @(negedge clk);
        chk("burst_accepts", 32'(n_req), 32'd6);
        chk("fill_latency", 32'(first_id_cyc - first_req_cyc), 32'(FillLat));

        // Fill to DEPTH with ID stalled, then free one slot
        bus.id_ready = 1'b0;
        redirect_to(32'h0000_0200);
        base = n_req;
        repeat (8) @(negedge clk);
        #1;
        chk("full_accepts", 32'(n_req - base), 32'd4);
        chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("full_occ", 32'(bus.occupancy), 32'd4);
        bus.id_ready = 1'b1;
        #1 chk("no_same_cycle_regrant", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.id_ready = 1'b0;
        #1;
        chk("regrant_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("regrant_addr", bus.imem_req_addr, 32'h0000_0210);
        bus.id_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Redirect with 3-cycle memory and responses in flight
        mem_lat = 3;
        repeat (8) @(negedge clk);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
        #1 chk("redir_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0; arm_first = 1'b1;
        #1;
        chk("redir_occ", 32'(bus.occupancy), 32'd0);
        chk("redir_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("redir_id_valid", 32'(bus.id_valid), 32'd0);
        repeat (12) @(negedge clk);
        chk("redir_first_pc", first_pc_after, 32'h0000_0100);

        // Redirect in the same cycle as a response, 2 pending
        bus.imem_req_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_occ", 32'(bus.occupancy), 32'd0);
        mem_lat = 2;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.imem_req_ready = 1'b0;
        redirect_to(32'h0000_0300);
        bus.imem_req_ready = 1'b1; arm_first = 1'b1; mem_lat = 1;
        repeat (8) @(negedge clk);
        chk("drop_first_pc", first_pc_after, 32'h0000_0300);

        // Fetch PC wraps at 2^XLEN
        redirect_to(32'hFFFF_FFF8);
        repeat (10) @(negedge clk);
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        // Asynchronous reset mid-burst
        mem_lat = 3;
        repeat (4) @(negedge clk);
        #2;
        x_reset = 1'b1;
        mem_q.delete(); exp_q.delete(); exp_fetch_pc = RESET_PC;
        bus.imem_rsp_valid = 1'b0;
        #1 chk_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        x_reset = 1'b0; arm_first = 1'b1;
        #1;
        chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
        repeat (10) @(negedge clk);
        chk("post_rst_first_pc", first_pc_after, RESET_PC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
